// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRelease,
    StRun,
    StErr
  } state_e;

  localparam int unsigned RELEASE_CYCLES = 2;

endpackage

// File: rtl/loader_word_asm.sv
// Packs a byte stream little-endian into 32-bit words; word_valid_o pulses the cycle after
// the fourth byte of a word is taken, and word_o holds its value until the next word completes.
module loader_word_asm (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [1:0]  lane_q, lane_d;
  logic [23:0] low_q, low_d;
  logic [31:0] word_q, word_d;
  logic        word_valid_q, word_valid_d;

  always_comb begin
    lane_d       = lane_q;
    low_d        = low_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    if (clear_i) begin
      lane_d = '0;
    end else if (byte_valid_i) begin
      lane_d = lane_q + 2'd1;
      unique case (lane_q)
        2'd0:    low_d[7:0]   = byte_i;
        2'd1:    low_d[15:8]  = byte_i;
        2'd2:    low_d[23:16] = byte_i;
        default: begin
          // Separate output register keeps word_o stable while the next word fills.
          word_d       = {byte_i, low_q};
          word_valid_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lane_q       <= '0;
      low_q        <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else begin
      lane_q       <= lane_d;
      low_q        <= low_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = word_valid_q;

endmodule

// File: rtl/imem_loader_ctrl.sv
// Loads a program into instruction memory from a byte stream, holding the core in reset
// until the load completes, then releasing it after a short settle period.
module imem_loader_ctrl
  import loader_pkg::*;
#(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned TIMEOUT = 1024,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW:0]   num_words,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  output logic          rx_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_waddr,
  output logic [31:0]   imem_wdata,
  output logic          core_rst_n,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   MaxWords    = (AW + 1)'(DEPTH);
  localparam logic [TW-1:0] TimeoutLast = TW'(TIMEOUT - 1);
  localparam logic [1:0]    RelLast     = 2'(RELEASE_CYCLES - 1);

  state_e        state_q, state_d;
  logic [AW:0]   num_q, num_d;
  logic [AW:0]   word_cnt_q, word_cnt_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [1:0]    rel_q, rel_d;
  logic [AW-1:0] waddr_q, waddr_d;

  logic        legal;
  logic        accept;
  logic        word_valid;
  logic        final_write;
  logic        timeout;
  logic        load_go;
  logic        asm_clear;
  logic [31:0] asm_word;

  assign legal       = (num_words != '0) && (num_words <= MaxWords);
  // Drops once every word's bytes are in, so trailing bytes are never taken.
  assign rx_ready    = (state_q == StLoad) && (word_cnt_q != num_q);
  assign accept      = rx_valid && rx_ready;
  assign imem_we     = word_valid && (state_q == StLoad);
  assign final_write = imem_we && (word_cnt_q == num_q);
  assign timeout     = (state_q == StLoad) && !accept && (tmo_q == TimeoutLast);
  assign asm_clear   = load_go || timeout;

  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    tmo_d      = tmo_q;
    rel_d      = rel_q;
    waddr_d    = waddr_q;
    load_go    = 1'b0;
    unique case (state_q)
      StIdle, StRun, StErr: begin
        if (start) begin
          if (legal) begin
            state_d    = StLoad;
            load_go    = 1'b1;
            num_d      = num_words;
            word_cnt_d = '0;
            byte_cnt_d = '0;
            tmo_d      = '0;
          end else begin
            state_d = StErr;
          end
        end
      end
      StLoad: begin
        if (accept) begin
          tmo_d      = '0;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            waddr_d    = word_cnt_q[AW-1:0];
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
        if (final_write) begin
          state_d = StRelease;
          rel_d   = '0;
        end else if (timeout) begin
          state_d = StErr;
        end
      end
      StRelease: begin
        if (rel_q == RelLast) begin
          state_d = StRun;
        end else begin
          rel_d = rel_q + 2'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      num_q      <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      tmo_q      <= '0;
      rel_q      <= '0;
      waddr_q    <= '0;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      word_cnt_q <= word_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      tmo_q      <= tmo_d;
      rel_q      <= rel_d;
      waddr_q    <= waddr_d;
    end
  end

  loader_word_asm u_word_asm (
    .clk_i        (clk),
    .rst_ni       (reset),
    .clear_i      (asm_clear),
    .byte_valid_i (accept),
    .byte_i       (rx_data),
    .word_o       (asm_word),
    .word_valid_o (word_valid)
  );

  assign imem_waddr = waddr_q;
  assign imem_wdata = asm_word;
  assign core_rst_n = (state_q == StRun);
  assign busy       = (state_q == StLoad) || (state_q == StRelease);
  assign done       = (state_q == StRun);
  assign err        = (state_q == StErr);

endmodule

// File: tb/tb_imem_loader_ctrl.sv
// Directed plus randomized bench for imem_loader_ctrl; expected writes are derived from the
// byte list sent, expected timing from the state-sequence rules.
module tb_imem_loader_ctrl;

  localparam int unsigned DEPTH   = 64;
  localparam int unsigned TIMEOUT = 40;
  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned NWW     = AW + 1;
  localparam int          RelCycles = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW:0]   num_words;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic          core_rst_n;
  logic          busy;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  imem_loader_ctrl #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .num_words  (num_words),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .core_rst_n (core_rst_n),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [7:0]    tx_q[$];
  logic [AW-1:0] wr_addr[$];
  logic [31:0]   wr_data[$];
  int            last_we_cyc = -100;
  int            we_long = 0;
  int            stab_err = 0;
  logic          we_prev = 1'b0;
  logic          prev_ok = 1'b0;
  logic [AW-1:0] pa;
  logic [31:0]   pd;
  int            used;
  int            nw;
  logic [AW:0]   badn;

  always @(posedge clk) cyc++;

  // Write monitor: records every strobe, flags multi-cycle strobes and drift while idle.
  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr.push_back(imem_waddr);
      wr_data.push_back(imem_wdata);
      last_we_cyc = cyc;
      if (we_prev) we_long++;
    end else if (reset && prev_ok && (imem_waddr !== pa || imem_wdata !== pd)) begin
      stab_err++;
    end
    we_prev = imem_we;
    pa      = imem_waddr;
    pd      = imem_wdata;
    prev_ok = reset;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [AW:0] n);
    start     = 1'b1;
    num_words = n;
    step();
    start = 1'b0;
  endtask

  task automatic fill_rand(input int nbytes);
    tx_q.delete();
    for (int i = 0; i < nbytes; i++) tx_q.push_back(8'($urandom));
  endtask

  // mode 0: back-to-back, 1: valid every other cycle, 2: random valid
  task automatic send_bytes(input int mode, input bit poke_start, output int cycles);
    int idx;
    bit ph;
    idx    = 0;
    ph     = 1'b0;
    cycles = 0;
    while (idx < tx_q.size() && cycles < 4000) begin
      case (mode)
        0:       rx_valid = 1'b1;
        1:       begin rx_valid = ph; ph = !ph; end
        default: rx_valid = ($urandom_range(0, 99) < 60);
      endcase
      rx_data = rx_valid ? tx_q[idx] : 8'($urandom);
      start   = poke_start && ($urandom_range(0, 9) == 0);
      if (poke_start) num_words = NWW'($urandom);
      if (rx_valid && rx_ready) idx++;
      step();
      cycles++;
    end
    rx_valid = 1'b0;
    start    = 1'b0;
    chk("all_bytes_taken", idx, tx_q.size());
  endtask

  task automatic expect_writes(input string tag, input int n);
    logic [31:0] w;
    chk({tag, "_count"}, wr_data.size(), n);
    for (int i = 0; i < n && i < wr_data.size(); i++) begin
      w = 32'(tx_q[4*i]) | (32'(tx_q[4*i+1]) << 8) | (32'(tx_q[4*i+2]) << 16)
        | (32'(tx_q[4*i+3]) << 24);
      chk($sformatf("%s_addr%0d", tag, i), 32'(wr_addr[i]), i);
      chk($sformatf("%s_data%0d", tag, i), wr_data[i], w);
    end
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic wait_run(input string tag);
    int dc;
    dc = -1;
    for (int k = 0; k < 12; k++) begin
      step();
      if (done === 1'b1) begin
        dc = cyc;
        break;
      end
    end
    chk({tag, "_done_reached"}, dc >= 0, 1);
    chk({tag, "_release_len"}, dc - last_we_cyc, 1 + RelCycles);
    chk({tag, "_core_rst_n"}, core_rst_n, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rx_ready"}, rx_ready, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d required=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = '0; num_words = '0;
    step();
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_we", imem_we, 0);
    chk("rst_waddr", 32'(imem_waddr), 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_core_rst_n", core_rst_n, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    reset = 1'b1;
    repeat (5) step();
    chk("idle_hold_busy", busy, 0);
    chk("idle_hold_err", err, 0);

    // Zero length from IDLE
    do_start('0);
    chk("len0_err", err, 1);
    chk("len0_core_rst_n", core_rst_n, 0);
    chk("len0_busy", busy, 0);

    // Normal two-word load, leaving ERR
    do_start(2);
    chk("load_busy", busy, 1);
    tx_q = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    send_bytes(0, 1'b0, used);
    repeat (1) @(negedge clk);
    #1;
    chk("normal_w0_const", wr_data.size() > 0 ? wr_data[0] : 32'hx, 32'h00500013);
    chk("normal_w1_const", wr_data.size() > 1 ? wr_data[1] : 32'hx, 32'h00100093);
    expect_writes("normal", 2);
    wait_run("normal");
    chk("normal_done", done, 1);

    // Reload from RUN
    do_start(1);
    chk("reload_core_rst_n", core_rst_n, 0);
    chk("reload_busy", busy, 1);
    fill_rand(4);
    send_bytes(0, 1'b0, used);
    step();
    expect_writes("reload", 1);
    wait_run("reload");

    // Oversize from RUN, then from ERR
    do_start(NWW'(DEPTH + 1));
    chk("over_run_err", err, 1);
    chk("over_run_core_rst_n", core_rst_n, 0);
    do_start('0);
    chk("err_stays_err", err, 1);

    // Stalled stream, valid every other cycle
    do_start(1);
    tx_q = '{8'h13, 8'h00, 8'h50, 8'h00};
    send_bytes(1, 1'b0, used);
    step();
    expect_writes("stall", 1);
    wait_run("stall");

    // Full depth back-to-back: one byte per cycle
    do_start(NWW'(DEPTH));
    fill_rand(4 * DEPTH);
    send_bytes(0, 1'b0, used);
    chk("full_one_byte_per_cycle", used, 4 * DEPTH);
    step();
    expect_writes("full", DEPTH);
    wait_run("full");

    // Randomized loads with spurious starts during LOAD
    for (int it = 0; it < 6; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        badn = ($urandom_range(0, 1) == 0) ? '0 : NWW'($urandom_range(DEPTH + 1, (1 << NWW) - 1));
        do_start(badn);
        chk($sformatf("rnd%0d_illegal_err", it), err, 1);
      end
      nw = $urandom_range(1, 6);
      do_start(NWW'(nw));
      fill_rand(4 * nw);
      send_bytes(2, 1'b1, used);
      step();
      expect_writes($sformatf("rnd%0d", it), nw);
      wait_run($sformatf("rnd%0d", it));
    end

    // Timeout with a partial word pending
    do_start(2);
    fill_rand(3);
    send_bytes(0, 1'b0, used);
    repeat (TIMEOUT - 1) step();
    chk("tmo_not_yet_err", err, 0);
    chk("tmo_not_yet_busy", busy, 1);
    step();
    chk("tmo_err", err, 1);
    chk("tmo_rx_ready", rx_ready, 0);
    expect_writes("tmo", 0);

    // Reset after 5 of 8 bytes
    do_start(2);
    fill_rand(8);
    tx_q = tx_q[0:4];
    send_bytes(0, 1'b0, used);
    step();
    expect_writes("pre_rst", 1);
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    #2 reset = 1'b0;
    #1;
    chk("midrst_rx_ready", rx_ready, 0);
    chk("midrst_we", imem_we, 0);
    chk("midrst_waddr", 32'(imem_waddr), 0);
    chk("midrst_wdata", imem_wdata, 0);
    chk("midrst_core_rst_n", core_rst_n, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_err", err, 0);
    step();
    step();
    reset = 1'b1;
    repeat (6) begin
      rx_data = 8'($urandom);
      step();
    end
    rx_valid = 1'b0;
    expect_writes("post_rst", 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_err", err, 0);
    chk("post_rst_rx_ready", rx_ready, 0);
    do_start(NWW'(DEPTH + 1));
    chk("idle_over_err", err, 1);

    chk("we_single_cycle", we_long, 0);
    chk("addr_data_stable", stab_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader_ctrl.md
IMEM_LOADER_CTRL -- requirements
Module: imem_loader_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 64, giving instruction-memory size in 32-bit words.
REQ-002 SHALL have parameter TIMEOUT, default 1024, giving the maximum idle cycles between accepted bytes during a load.
REQ-003 SHALL derive localparam AW = clog2(DEPTH) as the word-address width.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, single-cycle load request.
REQ-007 SHALL have port num_words, input, AW+1, number of words to load, sampled on start.
REQ-008 SHALL have port rx_valid, input, 1, byte-stream valid.
REQ-009 SHALL have port rx_data, input, 8, byte-stream data.
REQ-010 SHALL have port rx_ready, output, 1, byte-stream ready.
REQ-011 SHALL have port imem_we, output, 1, instruction-memory write strobe.
REQ-012 SHALL have port imem_waddr, output, AW, instruction-memory word address.
REQ-013 SHALL have port imem_wdata, output, 32, instruction-memory write data.
REQ-014 SHALL have port core_rst_n, output, 1, active-low hold for program counter and core.
REQ-015 SHALL have port busy, output, 1, high while in LOAD or RELEASE.
REQ-016 SHALL have port done, output, 1, high while in RUN.
REQ-017 SHALL have port err, output, 1, high while in ERR.

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, RELEASE, RUN, ERR.
REQ-019 SHALL go IDLE->LOAD on start when 1 <= num_words <= DEPTH, latching num_words and clearing the byte, word and timeout counters.
REQ-020 SHALL go IDLE->ERR on start when num_words is 0 or greater than DEPTH.
REQ-021 SHALL drive rx_ready=1 only in LOAD; a byte is accepted when rx_valid and rx_ready are both 1.
REQ-022 SHALL assemble bytes little-endian: the first accepted byte of a word goes to bits [7:0] and the fourth to [31:24].
REQ-023 SHALL, one cycle after the 4th byte of a word is accepted, pulse imem_we for exactly one cycle with imem_waddr = word index (starting at 0) and imem_wdata = the assembled word.
REQ-024 SHALL hold imem_waddr and imem_wdata stable when imem_we=0, and never assert imem_we outside that one-cycle pulse.
REQ-025 SHALL deassert rx_ready in the cycle the final byte of word num_words-1 is accepted, and ignore any further bytes.
REQ-026 SHALL move LOAD->RELEASE in the cycle the final imem_we pulse is issued.
REQ-027 SHALL remain in RELEASE for exactly 2 cycles, then enter RUN.
REQ-028 SHALL drive core_rst_n=1 only in RUN, and 0 in every other state.
REQ-029 SHALL go RUN->LOAD on a start with legal num_words, dropping core_rst_n the same cycle the state changes.
REQ-030 SHALL go RUN->ERR on a start with illegal num_words.
REQ-031 SHALL, in LOAD, increment the timeout counter each cycle with no byte accepted and clear it on every accepted byte.
REQ-032 SHALL go LOAD->ERR when the timeout counter reaches TIMEOUT; a partially assembled word is discarded and not written.
REQ-033 SHALL ignore start while in LOAD or RELEASE.
REQ-034 SHALL leave ERR only on start: to LOAD if num_words is legal, otherwise stay in ERR.
REQ-035 SHALL accept at most one byte per cycle and sustain one byte per cycle while rx_valid is continuously high.

Reset
REQ-036 SHALL, on reset low, immediately enter IDLE and force rx_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, core_rst_n=0, busy=0, done=0, err=0, with all counters at 0.
REQ-037 SHALL, when reset is asserted mid-load, write nothing further and load nothing from the aborted stream after release.
REQ-038 SHALL, after reset is released, remain in IDLE until start.

Structure
REQ-039 SHALL place the state enum type and the RELEASE_CYCLES=2 constant in shared package loader_pkg.
REQ-040 SHALL implement byte-to-word packing in one sub-module, loader_word_asm: byte in with valid, 32-bit word out with a word_valid pulse, and a clear input.
REQ-041 SHALL implement the FSM, counters and timeout in imem_loader_ctrl.

Verification
REQ-042 SHALL verify a normal load: start with num_words=2 and bytes 13,00,50,00,93,00,10,00 back-to-back -> imem_we at addr 0 = 0x00500013 and addr 1 = 0x00100093, then 2 RELEASE cycles, then core_rst_n=1 and done=1.
REQ-043 SHALL verify illegal lengths: start with num_words=0 -> ERR, err=1, core_rst_n=0; start with num_words=DEPTH+1 -> ERR.
REQ-044 SHALL verify a stalled stream: rx_valid toggled every other cycle with num_words=1 -> identical word written, with imem_we a single one-cycle pulse.
REQ-045 SHALL verify timeout: 3 bytes sent, then rx_valid=0 for TIMEOUT cycles -> ERR, and no imem_we for the partial word.
REQ-046 SHALL verify reset mid-load: reset asserted after 5 of 8 bytes -> all outputs at reset values immediately, and no write after release.
REQ-047 SHALL verify a reload from RUN: start with num_words=1 -> core_rst_n=0 the next cycle, the new word written at addr 0, then RUN again.
